s2mm_ring_ctrl: RTL and testbench
=================================

S2MM_RING_CTRL -- requirements
Module: s2mm_ring_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning the data beat width in bits (a power of 2, 64..512).
REQ-002 SHALL have parameter BURST_BYTES, default 4096, meaning the bytes per datamover command (a power of 2, at least DATA_W/8, at most 2^22).
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the fill, completion and ring-size counters.
REQ-004 SHALL have these ports, one per line:
- axi_aclk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level: run capture.
- overwrite_mode  in  1  1 = free-running wrap; 0 = stall when ring full.
- err_clear  in  1  pulse: leave ERROR.
- ring_base  in  32  ring start byte address, BURST_BYTES-aligned.
- ring_bursts  in  CNT_W  ring size in bursts, at least 1; sampled on IDLE->RUN.
- host_consume  in  1  pulse: host freed one burst.
- s_tdata  in  DATA_W  upstream data.
- s_tvalid  in  1  upstream data valid.
- s_tready  out  1  upstream data ready.
- m_cmd_tdata  out  72  datamover S2MM command.
- m_cmd_tvalid  out  1  command valid.
- m_cmd_tready  in  1  command ready.
- m_data_tdata  out  DATA_W  data to datamover.
- m_data_tvalid  out  1  data valid.
- m_data_tready  in  1  data ready.
- m_data_tlast  out  1  last beat of a burst.
- s2mm_wr_xfer_cmplt  in  1  one-cycle completion pulse.
- s2mm_err  in  1  datamover error.
- s2mm_halt  out  1  datamover halt request.
- fill_bursts  out  CNT_W  bursts written and not yet consumed.
- xfer_count  out  CNT_W  completions since reset, wrapping.
- wrap_flag  out  1  sticky: address wrapped to ring_base.
- overrun_flag  out  1  sticky: fill exceeded capacity.
- err_flag  out  1  sticky: s2mm_err seen.
- state  out  3  encoded FSM state.

Function
REQ-005 SHALL implement states IDLE=0, RUN=1, DRAIN=2, ERROR=3.
REQ-006 SHALL go IDLE->RUN when enable=1, latching ring_bursts into cap and setting the write pointer wr_idx to 0.
REQ-007 SHALL go RUN->DRAIN when enable=0, issuing no new commands from that cycle.
REQ-008 SHALL go DRAIN->IDLE once the in-flight burst's data is complete and outstanding completions reach 0.
REQ-009 SHALL go from any state to ERROR one cycle after s2mm_err=1, setting err_flag.
REQ-010 SHALL go ERROR->IDLE only on err_clear=1 while s2mm_err=0.
REQ-011 SHALL drive m_cmd_tdata as {8'h00, addr[31:0], 1'b0 DRE, 1'b1 EOF, 6'h00 DSA, 1'b1 Type, 23-bit BTT=BURST_BYTES}, where addr = ring_base + wr_idx*BURST_BYTES.
REQ-012 SHALL assert m_cmd_tvalid in RUN only when cmd_credit < 2 and, if overwrite_mode=0, fill_bursts + outstanding < cap.
REQ-013 SHALL advance wr_idx on each command handshake (tvalid&tready), wrapping from cap-1 to 0 and setting wrap_flag on the wrap.
REQ-014 SHALL keep cmd_credit as the count of accepted commands whose data beats are not all sent: +1 on command handshake, -1 on the tlast data handshake, both in one cycle = no change.
REQ-015 SHALL make data pass-through combinational: m_data_tvalid = s_tvalid & gate, and s_tready = m_data_tready & gate, where gate = (cmd_credit>0) & state in {RUN, DRAIN}.
REQ-016 SHALL count data handshakes in a beat counter of BURST_BYTES*8/DATA_W beats and drive m_data_tlast high on the final beat (combinational from the counter), the counter wrapping to 0 after it.
REQ-017 SHALL keep outstanding as the count of accepted commands not yet completed; a command and a completion in the same cycle = no change.
REQ-018 SHALL update fill_bursts by +1 per s2mm_wr_xfer_cmplt and -1 per host_consume, simultaneous = no change, saturating at 0 and at 2^CNT_W-1.
REQ-019 SHALL, in overwrite_mode=1, set overrun_flag when a completion makes fill_bursts > cap, and then hold fill_bursts at cap.
REQ-020 SHALL increment xfer_count by 1 per s2mm_wr_xfer_cmplt, modulo 2^CNT_W.
REQ-021 SHALL clear wrap_flag and overrun_flag only on the IDLE->RUN transition or on rst.
REQ-022 SHALL assert s2mm_halt in ERROR and in IDLE.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set state=IDLE, all counters, wr_idx, cmd_credit and flags to 0, m_cmd_tvalid=0 and m_data_tvalid=0, with s2mm_halt=1 in the next cycle.
REQ-024 SHALL give rst precedence over every other input, including a reset asserted mid-burst; the partial burst is abandoned.

Verification
REQ-025 Scenario: BURST_BYTES=4096, DATA_W=128, ring_base=0x1000_0000, cap=4, continuous data and completions -> commands to 0x1000_0000, 0x1000_1000, 0x1000_2000, 0x1000_3000, then 0x1000_0000 with wrap_flag=1; tlast on every 256th beat.
REQ-026 Scenario: overwrite_mode=0, cap=2, no host_consume -> after 2 completions m_cmd_tvalid stays 0 and s_tready stays 0 once credit is consumed; one host_consume -> exactly one more command issues.
REQ-027 Scenario: overwrite_mode=1, cap=2, no host_consume -> third completion sets overrun_flag=1 with fill_bursts=2.
REQ-028 Scenario: enable dropped at beat 100 of a burst -> state=DRAIN, beats 101..256 still pass, no new command, IDLE after last completion.
REQ-029 Scenario: s2mm_err pulse in RUN -> state=ERROR next cycle, s2mm_halt=1, m_data_tvalid=0, err_flag=1; err_clear -> IDLE.
REQ-030 Scenario: command handshake, tlast handshake and completion all in one cycle, plus host_consume together with a completion -> cmd_credit, outstanding and fill_bursts all unchanged.

Source files
------------

// File: rtl/s2mm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : s2mm_ring_ctrl
// Description : Streams upstream beats into a ring of fixed-size bursts through
//               an S2MM datamover, tracking fill level, completions and errors.
// Revision    : 1.0 - initial release
// ============================================================================
module s2mm_ring_ctrl #(
    parameter int DATA_W      = 128,
    parameter int BURST_BYTES = 4096,
    parameter int CNT_W       = 16
) (
    input  logic              axi_aclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              overwrite_mode,
    input  logic              err_clear,
    input  logic [31:0]       ring_base,
    input  logic [CNT_W-1:0]  ring_bursts,
    input  logic              host_consume,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [71:0]       m_cmd_tdata,
    output logic              m_cmd_tvalid,
    input  logic              m_cmd_tready,
    output logic [DATA_W-1:0] m_data_tdata,
    output logic              m_data_tvalid,
    input  logic              m_data_tready,
    output logic              m_data_tlast,
    input  logic              s2mm_wr_xfer_cmplt,
    input  logic              s2mm_err,
    output logic              s2mm_halt,
    output logic [CNT_W-1:0]  fill_bursts,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              wrap_flag,
    output logic              overrun_flag,
    output logic              err_flag,
    output logic [2:0]        state
);

    localparam int c_BEATS    = BURST_BYTES * 8 / DATA_W;
    localparam int c_BEAT_W   = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_BURST_SH = $clog2(BURST_BYTES);

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_ONE  = {{(c_BEAT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]      c_FILL_ONE  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [22:0]         c_BTT       = 23'(BURST_BYTES);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RUN   = 3'd1;
    localparam logic [2:0] c_ST_DRAIN = 3'd2;
    localparam logic [2:0] c_ST_ERROR = 3'd3;

    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_cap;
    logic [CNT_W-1:0]    r_wr_idx;
    logic [CNT_W-1:0]    r_outstanding;
    logic [CNT_W-1:0]    r_fill;
    logic [CNT_W-1:0]    r_xfer;
    logic [1:0]          r_cmd_credit;
    logic [c_BEAT_W-1:0] r_beat;
    logic                r_wrap;
    logic                r_overrun;
    logic                r_err;

    logic        w_start;
    logic        w_room;
    logic        w_gate;
    logic        w_cmd_valid;
    logic        w_cmd_hs;
    logic        w_data_hs;
    logic        w_last;
    logic        w_last_hs;
    logic [31:0] w_addr;
    logic [CNT_W:0] w_fill_inc;

    assign w_start = (r_state == c_ST_IDLE) && enable && !s2mm_err;

    // Without overwrite, never commit more bursts than the host has room for.
    assign w_room = overwrite_mode ||
                    (({1'b0, r_fill} + {1'b0, r_outstanding}) < {1'b0, r_cap});

    assign w_cmd_valid = (r_state == c_ST_RUN) && enable &&
                         (r_cmd_credit < 2'd2) && w_room;
    assign w_cmd_hs    = w_cmd_valid && m_cmd_tready;

    assign w_gate    = (r_cmd_credit != 2'd0) &&
                       ((r_state == c_ST_RUN) || (r_state == c_ST_DRAIN));
    assign w_data_hs = s_tvalid && m_data_tready && w_gate;
    assign w_last    = (r_beat == c_LAST_BEAT);
    assign w_last_hs = w_data_hs && w_last;

    assign w_addr     = ring_base + (32'(r_wr_idx) << c_BURST_SH);
    assign w_fill_inc = {1'b0, r_fill} + c_FILL_ONE;

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else if (s2mm_err) begin
            r_state <= c_ST_ERROR;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (enable) r_state <= c_ST_RUN;
                c_ST_RUN:   if (!enable) r_state <= c_ST_DRAIN;
                c_ST_DRAIN: if ((r_cmd_credit == 2'd0) && (r_outstanding == '0))
                                r_state <= c_ST_IDLE;
                c_ST_ERROR: if (err_clear) r_state <= c_ST_IDLE;
                default:    r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_cap    <= '0;
            r_wr_idx <= '0;
            r_wrap   <= 1'b0;
        end else if (w_start) begin
            r_cap    <= ring_bursts;
            r_wr_idx <= '0;
            r_wrap   <= 1'b0;
        end else if (w_cmd_hs) begin
            if (r_wr_idx == (r_cap - c_CNT_ONE)) begin
                r_wr_idx <= '0;
                r_wrap   <= 1'b1;
            end else begin
                r_wr_idx <= r_wr_idx + c_CNT_ONE;
            end
        end
    end

    // A halted datamover drops any partial burst, so the data bookkeeping restarts.
    always_ff @(posedge axi_aclk) begin
        if (rst || (r_state == c_ST_ERROR)) begin
            r_cmd_credit  <= 2'd0;
            r_beat        <= '0;
            r_outstanding <= '0;
        end else begin
            case ({w_cmd_hs, w_last_hs})
                2'b10:   r_cmd_credit <= r_cmd_credit + 2'd1;
                2'b01:   r_cmd_credit <= r_cmd_credit - 2'd1;
                default: r_cmd_credit <= r_cmd_credit;
            endcase
            if (w_data_hs) begin
                r_beat <= w_last ? '0 : (r_beat + c_BEAT_ONE);
            end
            case ({w_cmd_hs, s2mm_wr_xfer_cmplt})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_ONE;
                2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - c_CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_fill    <= '0;
            r_xfer    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (s2mm_wr_xfer_cmplt) begin
                r_xfer <= r_xfer + c_CNT_ONE;
            end
            if (s2mm_wr_xfer_cmplt && !host_consume) begin
                if (overwrite_mode && (w_fill_inc > {1'b0, r_cap})) begin
                    r_fill <= r_cap;
                end else if (r_fill != '1) begin
                    r_fill <= r_fill + c_CNT_ONE;
                end
            end else if (host_consume && !s2mm_wr_xfer_cmplt) begin
                if (r_fill != '0) r_fill <= r_fill - c_CNT_ONE;
            end
            if (w_start) begin
                r_overrun <= 1'b0;
            end else if (s2mm_wr_xfer_cmplt && !host_consume && overwrite_mode &&
                         (w_fill_inc > {1'b0, r_cap})) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (s2mm_err) begin
            r_err <= 1'b1;
        end
    end

    assign m_cmd_tdata   = {8'h00, w_addr, 1'b0, 1'b1, 6'h00, 1'b1, c_BTT};
    assign m_cmd_tvalid  = w_cmd_valid;
    assign m_data_tdata  = s_tdata;
    assign m_data_tvalid = s_tvalid && w_gate;
    assign s_tready      = m_data_tready && w_gate;
    assign m_data_tlast  = w_last;
    assign s2mm_halt     = (r_state == c_ST_IDLE) || (r_state == c_ST_ERROR);
    assign fill_bursts   = r_fill;
    assign xfer_count    = r_xfer;
    assign wrap_flag     = r_wrap;
    assign overrun_flag  = r_overrun;
    assign err_flag      = r_err;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_s2mm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_s2mm_ring_ctrl
// Description : Directed vector table plus multi-cycle ring scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s2mm_ring_ctrl;

    localparam int DATA_W = 128;
    localparam int BEATS  = 256;

    logic              axi_aclk;
    logic              rst;
    logic              enable;
    logic              overwrite_mode;
    logic              err_clear;
    logic [31:0]       ring_base;
    logic [15:0]       ring_bursts;
    logic              host_consume;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [71:0]       m_cmd_tdata;
    logic              m_cmd_tvalid;
    logic              m_cmd_tready;
    logic [DATA_W-1:0] m_data_tdata;
    logic              m_data_tvalid;
    logic              m_data_tready;
    logic              m_data_tlast;
    logic              s2mm_wr_xfer_cmplt;
    logic              s2mm_err;
    logic              s2mm_halt;
    logic [15:0]       fill_bursts;
    logic [15:0]       xfer_count;
    logic              wrap_flag;
    logic              overrun_flag;
    logic              err_flag;
    logic [2:0]        state;

    s2mm_ring_ctrl dut (
        .axi_aclk(axi_aclk), .rst(rst), .enable(enable),
        .overwrite_mode(overwrite_mode), .err_clear(err_clear),
        .ring_base(ring_base), .ring_bursts(ring_bursts),
        .host_consume(host_consume), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .m_cmd_tdata(m_cmd_tdata),
        .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready),
        .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid),
        .m_data_tready(m_data_tready), .m_data_tlast(m_data_tlast),
        .s2mm_wr_xfer_cmplt(s2mm_wr_xfer_cmplt), .s2mm_err(s2mm_err),
        .s2mm_halt(s2mm_halt), .fill_bursts(fill_bursts),
        .xfer_count(xfer_count), .wrap_flag(wrap_flag),
        .overrun_flag(overrun_flag), .err_flag(err_flag), .state(state)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    typedef struct packed {
        bit en, ow, crdy, sval, drdy, cmplt, cons;
        logic [2:0]  st;
        bit          cv, sr, mv;
        logic [15:0] fill;
        bit          halt;
        logic [31:0] addr;
        bit          wrap;
    } vec_t;

    vec_t vecs[12];

    int total = 0;
    int bad   = 0;
    int n_cmd, n_cmplt, n_beats, beat_mod, tlast_err, data_err, viol, cmd_limit;
    bit pend, auto_cmplt, stream_en, watch_cmd, watch_sr;
    bit last_cmd_hs, last_data_hs, last_tlast;
    logic [31:0] cmd_addr[16];
    bit          cmd_wrap[16];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at posedge+1, observe at negedge, model beats and commands.
    task automatic cyc(input bit f_cmplt, input bit f_consume);
        @(posedge axi_aclk); #1;
        s2mm_wr_xfer_cmplt = pend | f_cmplt;
        pend               = 1'b0;
        host_consume       = f_consume;
        m_cmd_tready       = (n_cmd < cmd_limit);
        s_tvalid           = stream_en;
        m_data_tready      = stream_en;
        s_tdata            = {$urandom, $urandom, $urandom, $urandom};
        if (s2mm_wr_xfer_cmplt) n_cmplt++;
        last_cmd_hs = 0; last_data_hs = 0; last_tlast = 0;
        @(negedge axi_aclk);
        if (m_cmd_tvalid && m_cmd_tready) begin
            last_cmd_hs = 1;
            if (n_cmd < 16) begin
                cmd_addr[n_cmd] = m_cmd_tdata[63:32];
                cmd_wrap[n_cmd] = wrap_flag;
            end
            n_cmd++;
        end
        if (m_data_tvalid && m_data_tready) begin
            last_data_hs = 1;
            last_tlast   = m_data_tlast;
            if (m_data_tlast !== (beat_mod == BEATS - 1)) tlast_err++;
            if (m_data_tdata !== s_tdata) data_err++;
            if (auto_cmplt && (beat_mod == BEATS - 1)) pend = 1'b1;
            beat_mod = (beat_mod + 1) % BEATS;
            n_beats++;
        end
        if ((watch_cmd && m_cmd_tvalid) || (watch_sr && s_tready)) viol++;
    endtask

    task automatic do_reset();
        @(posedge axi_aclk); #1;
        rst = 1; enable = 0; overwrite_mode = 0; err_clear = 0; host_consume = 0;
        s_tvalid = 0; m_cmd_tready = 0; m_data_tready = 0;
        s2mm_wr_xfer_cmplt = 0; s2mm_err = 0;
        n_cmd = 0; n_cmplt = 0; n_beats = 0; beat_mod = 0; tlast_err = 0;
        data_err = 0; viol = 0; cmd_limit = 100;
        pend = 0; auto_cmplt = 1; stream_en = 0; watch_cmd = 0; watch_sr = 0;
        @(posedge axi_aclk); #1;
        rst = 0;
        @(negedge axi_aclk);
    endtask

    initial begin
        rst = 1; enable = 0; overwrite_mode = 0; err_clear = 0;
        ring_base = 32'h1000_0000; ring_bursts = 16'd2; host_consume = 0;
        s_tdata = '0; s_tvalid = 0; m_cmd_tready = 0; m_data_tready = 0;
        s2mm_wr_xfer_cmplt = 0; s2mm_err = 0;

        //        en ow crdy sval drdy cmplt cons | st  cv sr mv fill  halt addr          wrap
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 16'd0, 1, 32'h1000_0000, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 16'd0, 1, 32'h1000_0000, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 0, 0, 3'd1, 1, 0, 0, 16'd0, 0, 32'h1000_0000, 0};
        vecs[3]  = '{1, 0, 1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 16'd0, 0, 32'h1000_0000, 0};
        vecs[4]  = '{1, 0, 1, 1, 1, 0, 0, 3'd1, 1, 1, 1, 16'd0, 0, 32'h1000_1000, 0};
        vecs[5]  = '{1, 0, 1, 1, 1, 0, 0, 3'd1, 0, 1, 1, 16'd0, 0, 32'h1000_0000, 1};
        vecs[6]  = '{1, 0, 0, 0, 1, 1, 0, 3'd1, 0, 1, 0, 16'd0, 0, 32'h1000_0000, 1};
        vecs[7]  = '{1, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 16'd1, 0, 32'h1000_0000, 1};
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 0, 16'd1, 0, 32'h1000_0000, 1};
        vecs[9]  = '{1, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 16'd0, 0, 32'h1000_0000, 1};
        vecs[10] = '{1, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 0, 16'd0, 0, 32'h1000_0000, 1};
        vecs[11] = '{1, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 16'd0, 0, 32'h1000_0000, 1};

        // Reset state
        do_reset();
        chk("rst_state", state, 3'd0);
        chk("rst_halt", s2mm_halt, 1'b1);
        chk("rst_cmd_tvalid", m_cmd_tvalid, 1'b0);
        chk("rst_fill", fill_bursts, 16'd0);
        chk("rst_xfer", xfer_count, 16'd0);
        chk("rst_flags", {wrap_flag, overrun_flag, err_flag}, 3'b000);

        // Vector table: cap=2, no overwrite
        ring_bursts = 16'd2;
        for (int i = 0; i < 12; i++) begin
            @(posedge axi_aclk); #1;
            enable = vecs[i].en; overwrite_mode = vecs[i].ow;
            m_cmd_tready = vecs[i].crdy; s_tvalid = vecs[i].sval;
            m_data_tready = vecs[i].drdy; s2mm_wr_xfer_cmplt = vecs[i].cmplt;
            host_consume = vecs[i].cons;
            s_tdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge axi_aclk);
            chk($sformatf("v%0d_state", i), state, vecs[i].st);
            chk($sformatf("v%0d_cmd_tvalid", i), m_cmd_tvalid, vecs[i].cv);
            chk($sformatf("v%0d_s_tready", i), s_tready, vecs[i].sr);
            chk($sformatf("v%0d_m_tvalid", i), m_data_tvalid, vecs[i].mv);
            chk($sformatf("v%0d_fill", i), fill_bursts, vecs[i].fill);
            chk($sformatf("v%0d_halt", i), s2mm_halt, vecs[i].halt);
            chk($sformatf("v%0d_addr", i), m_cmd_tdata[63:32], vecs[i].addr);
            chk($sformatf("v%0d_wrap", i), wrap_flag, vecs[i].wrap);
            if (vecs[i].cv)
                chk($sformatf("v%0d_cmd_word", i), m_cmd_tdata,
                    {8'h00, vecs[i].addr, 1'b0, 1'b1, 6'h00, 1'b1, 23'd4096});
        end

        // Reset mid-burst abandons the partial burst
        do_reset();
        ring_bursts = 16'd4; overwrite_mode = 1; enable = 1; stream_en = 1;
        for (int i = 0; i < 300 && n_beats < 50; i++) cyc(0, 0);
        chk("G_reached50", n_beats >= 50, 1'b1);
        do_reset();
        s_tvalid = 1; m_data_tready = 1;
        #1;
        chk("G_state", state, 3'd0);
        chk("G_halt", s2mm_halt, 1'b1);
        chk("G_mtvalid", m_data_tvalid, 1'b0);
        chk("G_credit", dut.r_cmd_credit, 2'd0);

        // Ring walk with wrap, cap=4, continuous completions
        ring_bursts = 16'd4; overwrite_mode = 1; enable = 1; stream_en = 1;
        for (int i = 0; i < 3000 && n_cmd < 5; i++) cyc(0, 0);
        chk("A_reach5", n_cmd >= 5, 1'b1);
        chk("A_addr0", cmd_addr[0], 32'h1000_0000);
        chk("A_addr1", cmd_addr[1], 32'h1000_1000);
        chk("A_addr2", cmd_addr[2], 32'h1000_2000);
        chk("A_addr3", cmd_addr[3], 32'h1000_3000);
        chk("A_addr4", cmd_addr[4], 32'h1000_0000);
        chk("A_wrap_before", cmd_wrap[3], 1'b0);
        chk("A_wrap_after", cmd_wrap[4], 1'b1);
        chk("A_tlast_errs", tlast_err, 0);
        chk("A_data_errs", data_err, 0);
        stream_en = 0;
        cyc(0, 0); cyc(0, 0);
        chk("A_xfer", xfer_count, 16'(n_cmplt));

        // Stall when full, one consume frees one command
        do_reset();
        ring_bursts = 16'd2; enable = 1; stream_en = 1;
        for (int i = 0; i < 2000 && n_cmplt < 2; i++) cyc(0, 0);
        chk("B_two_cmplt", n_cmplt, 2);
        cyc(0, 0); cyc(0, 0); cyc(0, 0);
        watch_cmd = 1; watch_sr = 1;
        repeat (100) cyc(0, 0);
        chk("B_stall_viol", viol, 0);
        chk("B_fill", fill_bursts, 16'd2);
        chk("B_ncmd", n_cmd, 2);
        watch_cmd = 0; watch_sr = 0;
        cyc(0, 1);
        repeat (700) cyc(0, 0);
        chk("B_ncmd_after", n_cmd, 3);
        chk("B_fill_after", fill_bursts, 16'd2);

        // Overwrite: third completion overruns cap=2
        do_reset();
        ring_bursts = 16'd2; overwrite_mode = 1; enable = 1; stream_en = 1;
        for (int i = 0; i < 2000 && n_cmplt < 2; i++) cyc(0, 0);
        cyc(0, 0);
        chk("C_fill2", fill_bursts, 16'd2);
        chk("C_no_overrun", overrun_flag, 1'b0);
        for (int i = 0; i < 2000 && n_cmplt < 3; i++) cyc(0, 0);
        cyc(0, 0);
        chk("C_three_cmplt", n_cmplt, 3);
        chk("C_overrun", overrun_flag, 1'b1);
        chk("C_fill_held", fill_bursts, 16'd2);

        // Enable dropped at beat 100 drains the burst
        do_reset();
        ring_bursts = 16'd4; overwrite_mode = 1; enable = 1; stream_en = 1; cmd_limit = 1;
        for (int i = 0; i < 500 && n_beats < 100; i++) cyc(0, 0);
        enable = 0; cmd_limit = 100; watch_cmd = 1;
        cyc(0, 0);
        chk("D_drain", state, 3'd2);
        for (int i = 0; i < 400 && state != 3'd0; i++) cyc(0, 0);
        chk("D_idle", state, 3'd0);
        chk("D_beats", n_beats, BEATS);
        chk("D_no_cmd", viol, 0);
        chk("D_ncmd", n_cmd, 1);
        chk("D_cmplt", n_cmplt, 1);

        // Error entry and exit
        do_reset();
        ring_bursts = 16'd4; overwrite_mode = 1; enable = 1; stream_en = 1;
        repeat (10) cyc(0, 0);
        chk("E_flowing", m_data_tvalid, 1'b1);
        s2mm_err = 1;
        cyc(0, 0);
        s2mm_err = 0;
        chk("E_state", state, 3'd3);
        chk("E_halt", s2mm_halt, 1'b1);
        chk("E_mtvalid", m_data_tvalid, 1'b0);
        chk("E_errflag", err_flag, 1'b1);
        err_clear = 1; s2mm_err = 1;
        cyc(0, 0);
        chk("E_clear_blocked", state, 3'd3);
        s2mm_err = 0; enable = 0;
        cyc(0, 0);
        err_clear = 0;
        chk("E_idle", state, 3'd0);
        chk("E_errflag_sticky", err_flag, 1'b1);

        // Simultaneous command, tlast, completion and consume
        do_reset();
        ring_bursts = 16'd4; overwrite_mode = 1; enable = 1; stream_en = 1;
        auto_cmplt = 0; cmd_limit = 1;
        for (int i = 0; i < 600 && n_beats < BEATS; i++) cyc(0, 0);
        cyc(1, 0);
        cmd_limit = 2;
        for (int i = 0; i < 600 && n_beats < 2 * BEATS - 1; i++) cyc(0, 0);
        cmd_limit = 3;
        cyc(1, 1);
        chk("F_precond", {last_cmd_hs, last_data_hs, last_tlast}, 3'b111);
        stream_en = 0;
        cyc(0, 0);
        chk("F_credit", dut.r_cmd_credit, 2'd1);
        chk("F_outstanding", dut.r_outstanding, 16'd1);
        chk("F_fill", fill_bursts, 16'd1);
        chk("F_xfer", xfer_count, 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
